// File: rtl/obi_arb2.sv
// Two-manager OBI arbiter in front of a single subordinate (RAM).
// Round-robin winner selection, zero-latency forward in idle, one outstanding transaction.
module obi_arb2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              m_req_i,
  output logic [1:0]              m_gnt_o,
  input  logic [2*ADDR_W-1:0]     m_addr_i,
  input  logic [2*DATA_W-1:0]     m_wdata_i,
  input  logic [2*(DATA_W/8)-1:0] m_be_i,
  input  logic [1:0]              m_we_i,
  output logic [1:0]              m_rvalid_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic                    m_err_o,
  output logic                    s_req_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_W/8-1:0]     s_be_o,
  output logic [DATA_W-1:0]       s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_W-1:0]       s_rdata_i,
  input  logic                    s_err_i,
  output logic [7:0]              err_cnt_o,
  output logic                    busy_o
);

  localparam int unsigned BE_W = DATA_W / 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StRsp  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic       sel_q, sel_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       win;
  logic       src;

  // With both requesting, the manager not served last wins.
  assign win = (&m_req_i) ? ~last_q : m_req_i[1];
  // Once in ADDR the latched selection is frozen.
  assign src = (state_q == StAddr) ? sel_q : win;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    sel_d      = sel_q;
    err_cnt_d  = err_cnt_q;
    m_gnt_o    = 2'b00;
    m_rvalid_o = 2'b00;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    s_req_o    = 1'b0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;

    case (state_q)
      StIdle: begin
        if (|m_req_i) begin
          s_req_o = 1'b1;
          if (s_gnt_i) begin
            m_gnt_o[win] = 1'b1;
            owner_d      = win;
            state_d      = StRsp;
          end else begin
            sel_d   = win;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        s_req_o = 1'b1;
        if (s_gnt_i) begin
          m_gnt_o[sel_q] = 1'b1;
          owner_d        = sel_q;
          state_d        = StRsp;
        end
      end
      StRsp: begin
        if (s_rvalid_i) begin
          m_rvalid_o[owner_q] = 1'b1;
          m_rdata_o           = s_rdata_i;
          m_err_o             = s_err_i;
          last_d              = owner_q;
          state_d             = StIdle;
          if (s_err_i && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (s_req_o) begin
      s_addr_o  = src ? m_addr_i[2*ADDR_W-1:ADDR_W] : m_addr_i[ADDR_W-1:0];
      s_we_o    = src ? m_we_i[1] : m_we_i[0];
      s_be_o    = src ? m_be_i[2*BE_W-1:BE_W] : m_be_i[BE_W-1:0];
      s_wdata_o = src ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0];
    end

    // Reset is synchronous, so outputs are silenced combinationally while it is held.
    if (rst_i) begin
      m_gnt_o    = 2'b00;
      m_rvalid_o = 2'b00;
      m_rdata_o  = '0;
      m_err_o    = 1'b0;
      s_req_o    = 1'b0;
      s_addr_o   = '0;
      s_we_o     = 1'b0;
      s_be_o     = '0;
      s_wdata_o  = '0;
    end
  end

  assign busy_o    = ~rst_i && (state_q != StIdle);
  assign err_cnt_o = rst_i ? 8'd0 : err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      sel_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: doc/obi_arb2.md
OBI_ARB2 -- requirements
Module: obi_arb2

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the OBI address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the OBI data width; byte-enable width is DATA_W/8.

Interface
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port m_req_i, input, 2 bits: per-manager request; bit n belongs to manager n.
REQ-006 The block SHALL have port m_gnt_o, output, 2 bits: per-manager grant.
REQ-007 The block SHALL have ports m_addr_i, m_wdata_i, m_be_i and m_we_i, all inputs: packed per-manager fields of 2*ADDR_W, 2*DATA_W, 2*DATA_W/8 and 2 bits; slice n belongs to manager n.
REQ-008 The block SHALL have ports m_rvalid_o (2 bits), m_rdata_o (DATA_W) and m_err_o (1 bit), all outputs: response to the owning manager; rdata and err are shared and qualified by m_rvalid_o.
REQ-009 The block SHALL have ports s_req_o, s_addr_o, s_we_o, s_be_o and s_wdata_o, all outputs: the request channel to the single subordinate (RAM).
REQ-010 The block SHALL have ports s_gnt_i, s_rvalid_i, s_rdata_i (DATA_W) and s_err_i, all inputs: the subordinate handshake and response.
REQ-011 The block SHALL have port err_cnt_o, output, 8 bits: saturating count of error responses.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high while the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR and RSP.
REQ-014 IDLE: with any m_req_i bit set, the block SHALL choose winner w combinationally.
- Round-robin: with both requesting, w is the manager not recorded in last_q.
- With one requesting, w is that manager.
REQ-015 IDLE: the block SHALL drive s_req_o=1 and s_addr/we/be/wdata from manager w in the same cycle (zero-latency forward).
REQ-016 In IDLE, if s_gnt_i=1, the block SHALL assert m_gnt_o[w] in that same cycle, store owner_q=w, and go to RSP.
REQ-017 In IDLE, if s_gnt_i=0, the block SHALL store sel_q=w and go to ADDR.
REQ-018 ADDR: the block SHALL hold s_req_o=1 with fields from manager sel_q only; a new request from the other manager SHALL NOT change the selection.
REQ-019 In ADDR, on s_gnt_i=1, the block SHALL assert m_gnt_o[sel_q] in that cycle, set owner_q=sel_q, and go to RSP.
REQ-020 RSP: the block SHALL hold s_req_o=0 and m_gnt_o=0; at most one transaction is outstanding.
REQ-021 In RSP, on s_rvalid_i=1, the block SHALL drive m_rvalid_o[owner_q]=1, m_rdata_o=s_rdata_i and m_err_o=s_err_i in the same cycle (combinational), set last_q=owner_q, and go to IDLE.
REQ-022 The block SHALL hold m_rvalid_o to 0 for the non-owner, and SHALL ignore s_rvalid_i outside RSP.
REQ-023 When s_rvalid_i=1 and s_err_i=1 are sampled in RSP, err_cnt_o SHALL increment by 1 on that edge; it saturates at 255 and does not wrap.
REQ-024 Outside IDLE/ADDR, s_addr_o, s_we_o, s_be_o and s_wdata_o SHALL be 0; m_rdata_o and m_err_o SHALL be 0 when no m_rvalid_o bit is set.
REQ-025 Back-to-back: a request from the other manager present on the cycle of RSP->IDLE SHALL be presented in IDLE on the next cycle, so minimum spacing between grants is 2 cycles.
REQ-026 A manager that drops m_req_i while in ADDR is a protocol violation; the block SHALL keep presenting the latched request until grant.

Reset
REQ-027 When rst_i=1 is sampled, the block SHALL force:
- state IDLE;
- last_q=1, so manager 0 wins the first tie;
- owner_q=0 and sel_q=0;
- err_cnt_o=0.
REQ-028 While rst_i=1, all outputs SHALL be 0 and busy_o SHALL be 0.
REQ-029 Reset in ADDR or RSP SHALL abandon the transaction: no m_gnt_o or m_rvalid_o is issued for it afterwards, and a late s_rvalid_i is ignored.

Verification
REQ-030 Single read: with RAM word 3 = 0x0000_3333 and manager 0 requesting addr 0x3, we=0, gnt immediate -> m_gnt_o=01 same cycle, then m_rvalid_o=01, m_rdata_o=0x0000_3333 on the next cycle.
REQ-031 Write: manager 1 writes 0x1337_C0DE to addr 0x1 with be=0xF -> m_gnt_o=10, then m_rvalid_o=10 with err=0; a following read of addr 0x1 returns 0x1337_C0DE.
REQ-032 Contention: both managers request continuously from reset -> grants alternate 0,1,0,1 and no manager gets two grants in a row.
REQ-033 Stalled grant: s_gnt_i held 0 for 3 cycles while manager 1 is in ADDR and manager 0 raises its request -> s_addr_o stays at manager 1's address and the grant goes to manager 1.
REQ-034 Errors: 300 responses with s_err_i=1 -> err_cnt_o counts 1..255 and then stays at 255.
REQ-035 Reset mid-operation: rst_i pulsed for 1 cycle in RSP, then s_rvalid_i=1 -> m_rvalid_o stays 00, busy_o=0, and err_cnt_o=0.
